uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Serial receiver; the receive-side counterpart of the UART transmitter in the game design's UART path.
- Takes the asynchronous rx pin and recovers 8N1 frames: 1 start bit, 8 data bits LSB first, at least 1 stop bit.
- Also accepts frames with 2 stop bits, which the transmitter emits; the extra stop bit is treated as idle line.
- Presents each received byte as a one-cycle valid pulse to the game logic.

Parameters:
- BAUDRATE, 115200, line bit rate in bits/s.
- CLK_RATE, 50000000, clk frequency in Hz.
- Derived localparam BIT_CNT = CLK_RATE/BAUDRATE (integer division, 434 at defaults).
- Derived localparam HALF_CNT = BIT_CNT/2 (217 at defaults).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- rx  in  1  serial input, asynchronous to clk, idle high.
- rx_data  out  8  last correctly framed byte.
- rx_valid  out  1  one-cycle pulse; rx_data is new and valid in that cycle.
- rx_frame_err  out  1  one-cycle pulse; stop bit sampled low.
- rx_busy  out  1  high while a frame is in progress (any state other than IDLE).

Behaviour:
- Reset (asynchronous, active-high):
  - Synchroniser flops are set to 1; state is IDLE; bit counter and clock counter are 0.
  - rx_data = 8'h00, rx_valid = 0, rx_frame_err = 0, rx_busy = 0.
  - Reset mid-frame aborts the frame with no pulse. After release, the block waits in IDLE for the next falling edge.
- Input sync: rx passes through 2 flops to give rx_s. The falling edge is detected as rx_s_d == 1 && rx_s == 0.
- Clock counter: 32-bit, cleared on every state change, otherwise increments each cycle.
- State IDLE:
  - On a falling edge, go to START.
- State START:
  - When the counter reaches HALF_CNT-1, sample rx_s (mid start bit).
  - rx_s = 1: glitch or false start; return to IDLE with no pulse.
  - rx_s = 0: go to DATA with bit index = 0.
- State DATA:
  - Each time the counter reaches BIT_CNT-1 (mid bit), shift rx_s into shift_reg[bit index], LSB first.
  - After index 7 is sampled, go to STOP.
- State STOP: when the counter reaches BIT_CNT-1, sample rx_s.
  - 1: rx_data <= shift register and rx_valid = 1 for exactly one cycle; go to IDLE.
  - 0: rx_frame_err = 1 for one cycle; rx_data unchanged; go to WAIT_HIGH.
- State WAIT_HIGH (break/framing recovery):
  - Stay until rx_s == 1, then go to IDLE.
  - No new frame is recognised while the line is held low.
- Latency:
  - rx_valid rises 2 sync cycles + 1 edge-detect cycle + HALF_CNT + 9·BIT_CNT cycles (+1 register) after the rx falling edge, i.e. mid stop bit.
  - The next start bit may begin immediately after the stop bit; it is detected because IDLE is re-entered half a bit early.
- rx_valid and rx_frame_err are never high in the same cycle.
- No flow control: a consumer that misses a pulse loses the byte; rx_data holds until the next good frame.
- Integer-division baud error must be under 2% for any parameter pair used; this is checked by the bench, not the RTL.

Decomposition:
- Shared package uart_pkg holds:
  - function bit_cnt(clk_rate, baud);
  - the state encoding IDLE/START/DATA/STOP/WAIT_HIGH (3-bit localparams);
  - the frame constant DATA_BITS = 8.
- One natural sub-module: uart_sync2, a 2-flop synchroniser with a reset-to-1 value, reused by other async inputs such as buttons.
- The FSM, counter and shift register stay in uart_rx.

Test Plan:
- Defaults: drive frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop) at 434 clk/bit -> rx_valid single pulse, rx_data = 8'hA5, rx_frame_err = 0.
- Loopback: uart_tx with 2 stop bits sends back-to-back 0x00, 0xFF, 0x3C -> three rx_valid pulses with those values in order, no errors.
- Glitch: rx low for 100 clk, then high -> no pulse, state returns to IDLE, rx_busy low after about 217 clk.
- Framing: frame 0x55 with the stop bit driven low, then the line held low for 2000 clk -> rx_frame_err one pulse, rx_data keeps its previous value, no new frame until rx returns high.
- Reset mid-frame: assert rst during bit 4 of 0x81, then send 0x42 -> only rx_valid with 8'h42; outputs are at reset values while rst is high.
- Baud tolerance: send 0x96 with the bit period 2% long (443 clk) and 2% short (425 clk) -> rx_data = 8'h96 both times.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, receiver state encoding and the
// baud divider helper used to size bit timers.
package uart_pkg;

  // Payload bits per frame (8N1).
  localparam int unsigned DATA_BITS = 8;

  // Receiver states. The 3-bit encoding is kept stable for external probes.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rx_state_e;

  // Clock cycles per line bit (integer division, truncating).
  function automatic int unsigned bit_cnt(input int unsigned clk_rate,
                                          input int unsigned baud);
    return clk_rate / baud;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for asynchronous single-bit inputs (serial pins,
// buttons). Both stages reset to RST_VAL so an idle-high line does not
// produce a spurious edge as reset is released.
module uart_sync2
  import uart_pkg::*;
#(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  // Next value: shift the raw input into the first stage.
  always_comb begin
    sync_d = {sync_q[0], d};
  end

  // Synchroniser stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {2{RST_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 (1 start bit, 8 data bits LSB first, >= 1 stop bit).
// A second stop bit simply looks like idle line. Each good byte is reported
// with a one-cycle rx_valid pulse; a low stop bit gives a one-cycle
// rx_frame_err pulse and the receiver then waits for the line to go high.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned BAUDRATE = 115200,
  parameter int unsigned CLK_RATE = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int unsigned BIT_CNT  = bit_cnt(CLK_RATE, BAUDRATE);
  localparam int unsigned HALF_CNT = BIT_CNT / 2;
  localparam logic [31:0] BIT_LAST  = 32'(BIT_CNT - 1);
  localparam logic [31:0] HALF_LAST = 32'(HALF_CNT - 1);
  localparam logic [2:0]  LAST_IDX  = 3'(DATA_BITS - 1);

  // Synchronised line and its one-cycle-delayed copy for edge detection.
  logic rx_s;
  logic rx_s_d_q;
  logic fall;

  rx_state_e             state_q,   state_d;
  logic [31:0]           cnt_q,     cnt_d;
  logic [2:0]            bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0]  shift_q,   shift_d;
  logic [DATA_BITS-1:0]  data_q,    data_d;
  logic                  valid_q,   valid_d;
  logic                  ferr_q,    ferr_d;
  logic                  busy_q,    busy_d;

  uart_sync2 #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (rx),
    .q  (rx_s)
  );

  assign fall = rx_s_d_q && !rx_s;

  // Next-state logic: mid-bit sampling FSM with a free-running bit timer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 32'd1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (fall) begin
          state_d = START;
        end
      end

      START: begin
        // Re-check the line half a bit in to reject glitches.
        if (cnt_q == HALF_LAST) begin
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            bit_idx_d = '0;
          end
        end
      end

      DATA: begin
        // The timer restarts per bit so every sample stays mid-bit.
        if (cnt_q == BIT_LAST) begin
          shift_d[bit_idx_q] = rx_s;
          cnt_d              = '0;
          if (bit_idx_q == LAST_IDX) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end

      STOP: begin
        if (cnt_q == BIT_LAST) begin
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_HIGH;
          end
        end
      end

      WAIT_HIGH: begin
        // A held-low line (break) must not be mistaken for a start bit.
        if (rx_s) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end

    busy_d = (state_d != IDLE);
  end

  // State, timer, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s_d_q  <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      rx_s_d_q  <= rx_s;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
    end
  end

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_frame_err = ferr_q;
  assign rx_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx. The stimulus driver announces, per frame,
// the outcome the line protocol dictates (good byte or framing error) and the
// cycle window in which it must appear; a compare process checks every cycle.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int unsigned BAUD = 115200;
  localparam int unsigned CLKR = 50000000;
  localparam int BIT  = int'(CLKR / BAUD);   // 434
  localparam int HALF = BIT / 2;             // 217

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_busy;

  uart_rx #(
    .BAUDRATE(BAUD),
    .CLK_RATE(CLKR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_frame_err(rx_frame_err),
    .rx_busy     (rx_busy)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         err;
    logic [7:0] data;
    int         nom;
  } exp_t;

  exp_t       expq[$];
  logic [7:0] model_data = 8'h00;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every cycle: reset values while in reset, otherwise pulses must match the
  // announced outcomes in order and rx_data must hold between good frames.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      model_data = 8'h00;
      chk("rst_rx_data", 32'(rx_data), 32'h0);
      chk("rst_rx_valid", 32'(rx_valid), 32'h0);
      chk("rst_rx_frame_err", 32'(rx_frame_err), 32'h0);
      chk("rst_rx_busy", 32'(rx_busy), 32'h0);
    end else begin
      if (rx_valid && rx_frame_err) begin
        chk("valid_and_ferr_exclusive", 32'({rx_valid, rx_frame_err}), 32'h0);
      end else if (rx_valid || rx_frame_err) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: valid=%0b ferr=%0b data=%0h at cycle %0d, expected no pulse",
                   rx_valid, rx_frame_err, rx_data, cyc);
        end else begin
          e = expq.pop_front();
          chk("pulse_is_frame_err", 32'(rx_frame_err), 32'(e.err));
          checks++;
          if (cyc < e.nom || cyc > e.nom + 1) begin
            errors++;
            $display("FAIL pulse_time: pulse at cycle %0d, expected %0d..%0d", cyc, e.nom, e.nom + 1);
          end
          if (!e.err) begin
            model_data = e.data;
          end
        end
      end
      chk("rx_data_model", 32'(rx_data), 32'(model_data));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one frame; if announce is set, record the outcome the receiver must
  // report: mid-stop-bit sample = falling edge + 2 sync + 1 detect + HALF + 9*BIT.
  task automatic send_frame(input logic [7:0] d, input int per, input int nstop,
                            input bit good_stop, input bit announce);
    exp_t e;
    if (announce) begin
      e.err  = !good_stop;
      e.data = d;
      e.nom  = cyc + 3 + HALF + 9 * BIT;
      expq.push_back(e);
    end
    rx = 1'b0;
    tick(per);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(per);
    end
    rx = good_stop;
    tick(per * nstop);
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (expq.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d announced pulses missing after %0d cycles, expected 0",
               name, expq.size(), budget);
      expq.delete();
    end
  endtask

  // Guard on the chosen parameter pair: integer-division baud error below 2%.
  initial begin
    longint unsigned actual;
    actual = longint'(CLKR) / longint'(BIT);
    if ((actual > BAUD ? actual - BAUD : BAUD - actual) * 50 >= BAUD) begin
      $display("FAIL baud_error: actual rate %0d, expected within 2%% of %0d", actual, BAUD);
      $fatal(1);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

  initial begin
    int n0;
    rst = 1'b1;
    rx  = 1'b1;
    tick(3);
    chk("reset_rx_data", 32'(rx_data), 32'h00);
    chk("reset_rx_busy", 32'(rx_busy), 32'h0);
    rst = 1'b0;
    tick(20);
    chk("idle_busy", 32'(rx_busy), 32'h0);

    // Single frame at nominal rate.
    send_frame(8'hA5, BIT, 1, 1'b1, 1'b1);
    drain("a5", 2 * BIT);
    chk("lit_a5", 32'(rx_data), 32'hA5);
    tick(200);

    // Transmitter-style back-to-back frames with 2 stop bits.
    send_frame(8'h00, BIT, 2, 1'b1, 1'b1);
    send_frame(8'hFF, BIT, 2, 1'b1, 1'b1);
    send_frame(8'h3C, BIT, 2, 1'b1, 1'b1);
    drain("loopback", 2 * BIT);
    chk("lit_3c", 32'(rx_data), 32'h3C);
    tick(200);

    // Glitch: 100-cycle low pulse is rejected at the mid-start check.
    n0 = cyc;
    rx = 1'b0;
    tick(50);
    chk("glitch_busy_rises", 32'(rx_busy), 32'h1);
    tick(50);
    rx = 1'b1;
    tick(HALF - 105);
    chk("glitch_busy_before_check", 32'(rx_busy), 32'h1);
    tick(10);
    chk("glitch_busy_after_check", 32'(rx_busy), 32'h0);
    chk("glitch_elapsed", 32'(cyc - n0), 32'(HALF + 5));
    tick(2 * BIT);

    // Framing error: stop bit low, then line held low (break).
    send_frame(8'h55, BIT, 1, 1'b0, 1'b1);
    drain("ferr", 2 * BIT);
    tick(2000);
    chk("break_busy", 32'(rx_busy), 32'h1);
    chk("ferr_data_kept", 32'(rx_data), 32'h3C);
    rx = 1'b1;
    tick(10);
    chk("break_released_busy", 32'(rx_busy), 32'h0);
    tick(200);

    // Reset during bit 4 of 0x81 aborts the frame with no pulse.
    rx = 1'b0;
    tick(BIT);
    for (int i = 0; i < 4; i++) begin
      rx = (8'h81 >> i) & 8'h01;
      tick(BIT);
    end
    rx = 1'b0;
    tick(BIT / 2);
    rst = 1'b1;
    #1;
    chk("async_rst_data", 32'(rx_data), 32'h00);
    chk("async_rst_busy", 32'(rx_busy), 32'h0);
    rx = 1'b1;
    tick(5);
    rst = 1'b0;
    tick(300);
    chk("post_rst_idle", 32'(rx_busy), 32'h0);
    send_frame(8'h42, BIT, 1, 1'b1, 1'b1);
    drain("after_rst", 2 * BIT);
    chk("lit_42", 32'(rx_data), 32'h42);
    tick(200);

    // Bit period 2% long, then 2% short.
    send_frame(8'h96, 443, 1, 1'b1, 1'b1);
    drain("slow", 2 * BIT);
    chk("lit_96_slow", 32'(rx_data), 32'h96);
    tick(200);
    send_frame(8'h69, 425, 1, 1'b1, 1'b1);
    drain("fast_pre", 2 * BIT);
    chk("lit_69_fast", 32'(rx_data), 32'h69);
    tick(200);
    send_frame(8'h96, 425, 1, 1'b1, 1'b1);
    drain("fast", 2 * BIT);
    chk("lit_96_fast", 32'(rx_data), 32'h96);
    tick(2 * BIT);

    chk("no_pending_pulses", 32'(expq.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
